// File: rtl/inject_age_stamper.sv
// Injection-side FIFO that stamps each accepted flit with the local cycle time.
// Optional INJ_STARVE_CNT_EN adds a saturating head-starvation counter and flag.
module inject_age_stamper #(
  parameter int unsigned FLIT_W   = 64,
  parameter int unsigned TIME_W   = 8,
  parameter int unsigned TIME_LSB = 0,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FLIT_W-1:0]        in_flit,
  output logic                     inj_valid,
  output logic [FLIT_W-1:0]        inj_flit,
  input  logic                     inj_grant,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef INJ_STARVE_CNT_EN
  ,
  output logic [7:0]               starve_cnt,
  output logic                     starve_flag
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [TIME_W-1:0]  tcnt;
  logic [FLIT_W-1:0]  flit_mem [DEPTH];
  logic [TIME_W-1:0]  time_mem [DEPTH];
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Extra wrap bit distinguishes full from empty when indices coincide.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = ~full;
  assign inj_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = inj_valid & inj_grant;
  assign occupancy = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      tcnt   <= '0;
    end else begin
      tcnt <= tcnt + TIME_W'(1);
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Payload storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      flit_mem[wr_ptr[AW-1:0]] <= in_flit;
      time_mem[wr_ptr[AW-1:0]] <= tcnt;
    end
  end

  always_comb begin
    inj_flit = '0;
    if (inj_valid) begin
      inj_flit                      = flit_mem[rd_ptr[AW-1:0]];
      inj_flit[TIME_LSB +: TIME_W]  = time_mem[rd_ptr[AW-1:0]];
    end
  end

`ifdef INJ_STARVE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || pop) begin
      starve_cnt <= '0;
    end else if (inj_valid && (starve_cnt != 8'hFF)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  assign starve_flag = (starve_cnt == 8'hFF);
`endif

endmodule
